supply_seq_wrapper: RTL and testbench
=====================================

// Module: supply_seq_wrapper
// PURPOSE
//   Generalised supply-tie wrapper: replaces constant VDD/VSS tie-offs with a
//   sequenced set of NUM_DOM supply enables driven to a wrapped __w_sup DUT.
//   Brings domains up in order 0..NUM_DOM-1 and down in reverse, RAMP_CYC cycles
//   per step. Isolates the DUT data ports whenever the DUT is not fully powered.
// PARAMETERS
//   NUM_DOM   2  number of supply domains, >=1
//   WIDTH     1  data width of in/out and the DUT data ports, >=1
//   RAMP_CYC  4  cycles per sequencing step, >=1
//   ISO_VAL   0  WIDTH-bit value driven on out while isolated
// PORTS
//   clk       input   1        single clock, all state on rising edge
//   rst       input   1        synchronous reset, active-high
//   pwr_req   input   1        level request: 1 = power up, 0 = power down
//   in        input   WIDTH    data toward DUT
//   out       output  WIDTH    data from DUT, isolated when pwr_good=0
//   dut_in    output  WIDTH    data to DUT in port
//   dut_out   input   WIDTH    data from DUT out port
//   sup_en    output  NUM_DOM  per-domain supply enable (VDD_val of domain i)
//   pwr_good  output  1        all domains up and settled; isolation released
//   busy      output  1        sequencer in RAMP_UP or RAMP_DOWN
//   state     output  2        00 OFF, 01 RAMP_UP, 10 ON, 11 RAMP_DOWN
// BEHAVIOUR
//   Reset: state=OFF, sup_en=0, pwr_good=0, busy=0, idx=0, cnt=0; reset at any
//     time (incl. mid-ramp) drops all enables on that edge, no sequencing.
//   Regs: idx = highest enabled domain ($clog2(NUM_DOM) bits, min 1);
//     cnt counts 0..RAMP_CYC-1 ($clog2(RAMP_CYC) bits, min 1), no wrap past max.
//   OFF: pwr_req=1 -> RAMP_UP, sup_en[0]<=1, idx<=0, cnt<=0.
//   RAMP_UP, pwr_req=1: cnt<RAMP_CYC-1 -> cnt++; cnt==RAMP_CYC-1 ->
//     idx==NUM_DOM-1: state<=ON, pwr_good<=1; else idx++, sup_en[idx+1]<=1, cnt<=0.
//   ON: pwr_req=0 -> RAMP_DOWN, pwr_good<=0 (isolation on that edge), cnt<=0.
//   RAMP_DOWN, pwr_req=0: cnt==RAMP_CYC-1 -> sup_en[idx]<=0, cnt<=0;
//     idx==0: state<=OFF; else idx--. Otherwise cnt++.
//   Reversal: RAMP_UP with pwr_req=0 -> RAMP_DOWN, cnt<=0, idx kept (idx domain
//     dropped RAMP_CYC cycles later). RAMP_DOWN with pwr_req=1 -> RAMP_UP,
//     cnt<=0, idx kept (next domain enabled RAMP_CYC cycles later; if
//     idx==NUM_DOM-1 then ON after RAMP_CYC). pwr_req checked before cnt terminal.
//   Latency: pwr_req rise sampled at edge E (from OFF) -> sup_en[k] high after
//     edge E+k*RAMP_CYC; pwr_good high after edge E+NUM_DOM*RAMP_CYC.
//     Fall sampled in ON at edge F -> pwr_good low after F; sup_en[k] low after
//     F+(NUM_DOM-k)*RAMP_CYC; state OFF on same edge as sup_en[0] drops.
//   sup_en stays thermometer-coded (contiguous from bit 0) at all times.
//   Isolation (comb. from registered pwr_good): pwr_good=1 -> dut_in=in,
//     out=dut_out; else dut_in=0, out=ISO_VAL. busy = state is 01 or 11.
//   NUM_DOM=1 or RAMP_CYC=1 degenerate correctly (single step / 1-cycle steps).
// TESTING
//   Defaults; rst 2 cycles, req=1 at edge 0 -> sup_en 01 after e0, 11 after e4,
//     pwr_good=1 after e8; out tracks dut_out only from then on.
//   From ON, req=0 at edge 0 -> pwr_good=0,out=ISO_VAL after e0; sup_en 01 after
//     e4, 00 and state=OFF after e8.
//   req=1 then req=0 at edge 2 (RAMP_UP, idx 0) -> RAMP_DOWN; sup_en[0] drops
//     after e6; sup_en[1] never asserted; pwr_good never 1.
//   During RAMP_DOWN at idx=1, req=1 -> RAMP_UP, pwr_good=1 4 cycles later,
//     sup_en stays 11 throughout.
//   rst asserted mid RAMP_UP (sup_en=11) -> next edge sup_en=00, state=OFF,
//     pwr_good=0; stays OFF while req=0.
//   NUM_DOM=3, RAMP_CYC=1, WIDTH=8, ISO_VAL=8'hA5 -> sup_en 001,011,111 on
//     successive edges, pwr_good one edge later; out=8'hA5 while not good.

Source files
------------

// File: rtl/supply_seq_wrapper.sv
// Supply sequencer replacing constant tie-offs: ramps NUM_DOM supply enables up
// in order and down in reverse, isolating the wrapped DUT until fully powered.
module supply_seq_wrapper #(
    parameter int              NUM_DOM  = 2,
    parameter int              WIDTH    = 1,
    parameter int              RAMP_CYC = 4,
    parameter logic [WIDTH-1:0] ISO_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwr_req,
    input  logic [WIDTH-1:0]   in,
    output logic [WIDTH-1:0]   out,
    output logic [WIDTH-1:0]   dut_in,
    input  logic [WIDTH-1:0]   dut_out,
    output logic [NUM_DOM-1:0] sup_en,
    output logic               pwr_good,
    output logic               busy,
    output logic [1:0]         state
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int CNT_W = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DOM - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAMP_CYC - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_UP   = 2'b01,
        S_ON   = 2'b10,
        S_DOWN = 2'b11
    } state_t;

    state_t             st, st_n;
    logic [NUM_DOM-1:0] sup_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               good_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_OFF;
            sup_en   <= '0;
            idx      <= '0;
            cnt      <= '0;
            pwr_good <= 1'b0;
        end else begin
            st       <= st_n;
            sup_en   <= sup_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            pwr_good <= good_n;
        end
    end

    // A reversal of pwr_req takes priority over the step counter reaching its end.
    always_comb begin
        st_n   = st;
        sup_n  = sup_en;
        idx_n  = idx;
        cnt_n  = cnt;
        good_n = pwr_good;
        case (st)
            S_OFF: begin
                if (pwr_req) begin
                    st_n  = S_UP;
                    sup_n = NUM_DOM'(1);
                    idx_n = '0;
                    cnt_n = '0;
                end
            end
            S_UP: begin
                if (!pwr_req) begin
                    st_n  = S_DOWN;
                    cnt_n = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end else if (idx == IDX_MAX) begin
                    st_n   = S_ON;
                    good_n = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                    cnt_n = '0;
                    for (int unsigned i = 0; i < NUM_DOM; i++) begin
                        if (i == 32'(idx) + 32'd1) sup_n[i] = 1'b1;
                    end
                end
            end
            S_ON: begin
                if (!pwr_req) begin
                    st_n   = S_DOWN;
                    good_n = 1'b0;
                    cnt_n  = '0;
                end
            end
            S_DOWN: begin
                if (pwr_req) begin
                    st_n  = S_UP;
                    cnt_n = '0;
                end else if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    for (int unsigned i = 0; i < NUM_DOM; i++) begin
                        if (i == 32'(idx)) sup_n[i] = 1'b0;
                    end
                    if (idx == '0) st_n = S_OFF;
                    else           idx_n = idx - 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

    assign dut_in = pwr_good ? in      : '0;
    assign out    = pwr_good ? dut_out : ISO_VAL;
    assign busy   = (st == S_UP) || (st == S_DOWN);
    assign state  = st;

endmodule

// File: tb/tb_supply_seq_wrapper.sv
// Directed bench for supply_seq_wrapper: default configuration plus a
// 3-domain, 1-cycle-step, 8-bit instance, checked through an expectation queue.
module tb_supply_seq_wrapper;

    localparam logic [1:0] OFF = 2'b00, RU = 2'b01, ON = 2'b10, RD = 2'b11;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic       rst_a = 1'b1, req_a = 1'b0, in_a = 1'b0, dout_a = 1'b0;
    logic       out_a, din_a, good_a, busy_a;
    logic [1:0] sup_a, st_a;

    supply_seq_wrapper #(.NUM_DOM(2), .WIDTH(1), .RAMP_CYC(4), .ISO_VAL(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .pwr_req(req_a), .in(in_a), .out(out_a),
        .dut_in(din_a), .dut_out(dout_a), .sup_en(sup_a), .pwr_good(good_a),
        .busy(busy_a), .state(st_a)
    );

    // 3-domain, single-cycle steps, 8-bit data
    logic       rst_b = 1'b1, req_b = 1'b0;
    logic [7:0] in_b = 8'h00, dout_b = 8'h00, out_b, din_b;
    logic       good_b, busy_b;
    logic [2:0] sup_b;
    logic [1:0] st_b;

    supply_seq_wrapper #(.NUM_DOM(3), .WIDTH(8), .RAMP_CYC(1), .ISO_VAL(8'hA5)) dut_b (
        .clk(clk), .rst(rst_b), .pwr_req(req_b), .in(in_b), .out(out_b),
        .dut_in(din_b), .dut_out(dout_b), .sup_en(sup_b), .pwr_good(good_b),
        .busy(busy_b), .state(st_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.val)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    // Pushes the state expected after the coming edge, then checks it there.
    task automatic step_a(input string tag, input logic r, input logic req,
                          input logic [1:0] est, input logic [1:0] esup, input logic eg);
        logic di, dout, eo, ed, eb;
        di     = 1'($urandom_range(0, 1));
        dout   = 1'($urandom_range(0, 1));
        rst_a  = r;
        req_a  = req;
        in_a   = di;
        dout_a = dout;
        eb = (est == RU) || (est == RD);
        eo = eg ? dout : 1'b0;
        ed = eg ? di   : 1'b0;
        sb.push_back('{tag, {24'b0, est, eb, eg, esup, eo, ed}});
        tick();
        compare({24'b0, st_a, busy_a, good_a, sup_a, out_a, din_a});
    endtask

    task automatic step_b(input string tag, input logic r, input logic req,
                          input logic [1:0] est, input logic [2:0] esup, input logic eg);
        logic [7:0] di, dout, eo, ed;
        logic       eb;
        di     = 8'($urandom);
        dout   = 8'($urandom);
        rst_b  = r;
        req_b  = req;
        in_b   = di;
        dout_b = dout;
        eb = (est == RU) || (est == RD);
        eo = eg ? dout : 8'hA5;
        ed = eg ? di   : 8'h00;
        sb.push_back('{tag, {9'b0, est, eb, eg, esup, eo, ed}});
        tick();
        compare({9'b0, st_b, busy_b, good_b, sup_b, out_b, din_b});
    endtask

    task automatic power_up_a(input string pfx);
        for (int e = 0; e < 10; e++)
            step_a($sformatf("%s_up_e%0d", pfx, e), 1'b0, 1'b1,
                   (e >= 8) ? ON : RU, {e >= 4, 1'b1}, e >= 8);
    endtask

    task automatic power_down_a(input string pfx);
        for (int e = 0; e < 10; e++)
            step_a($sformatf("%s_dn_e%0d", pfx, e), 1'b0, 1'b0,
                   (e >= 8) ? OFF : RD, (e < 4) ? 2'b11 : (e < 8) ? 2'b01 : 2'b00, 1'b0);
    endtask

    initial begin
        // default instance: reset, full up, hold, full down
        step_a("rst0", 1'b1, 1'b0, OFF, 2'b00, 1'b0);
        step_a("rst1", 1'b1, 1'b0, OFF, 2'b00, 1'b0);
        power_up_a("a");
        step_a("hold_on0", 1'b0, 1'b1, ON, 2'b11, 1'b1);
        step_a("hold_on1", 1'b0, 1'b1, ON, 2'b11, 1'b1);
        power_down_a("a");

        // reversal during RAMP_UP at idx 0
        for (int e = 0; e < 10; e++)
            step_a($sformatf("rev_up_e%0d", e), 1'b0, e < 2,
                   (e < 2) ? RU : (e < 6) ? RD : OFF, (e < 6) ? 2'b01 : 2'b00, 1'b0);

        // reversal during RAMP_DOWN at idx 1
        power_up_a("b");
        for (int f = 0; f < 8; f++)
            step_a($sformatf("rev_dn_f%0d", f), 1'b0, f >= 2,
                   (f < 2) ? RD : (f < 6) ? RU : ON, 2'b11, f >= 6);

        // reset in the middle of a ramp with both domains enabled
        power_down_a("c");
        for (int e = 0; e < 6; e++)
            step_a($sformatf("mid_up_e%0d", e), 1'b0, 1'b1, RU, {e >= 4, 1'b1}, 1'b0);
        step_a("mid_rst", 1'b1, 1'b0, OFF, 2'b00, 1'b0);
        for (int e = 0; e < 3; e++)
            step_a($sformatf("post_rst_e%0d", e), 1'b0, 1'b0, OFF, 2'b00, 1'b0);

        // three domains, single-cycle steps
        step_b("b_rst0", 1'b1, 1'b0, OFF, 3'b000, 1'b0);
        step_b("b_rst1", 1'b1, 1'b0, OFF, 3'b000, 1'b0);
        step_b("b_up_e0", 1'b0, 1'b1, RU, 3'b001, 1'b0);
        step_b("b_up_e1", 1'b0, 1'b1, RU, 3'b011, 1'b0);
        step_b("b_up_e2", 1'b0, 1'b1, RU, 3'b111, 1'b0);
        step_b("b_up_e3", 1'b0, 1'b1, ON, 3'b111, 1'b1);
        step_b("b_up_e4", 1'b0, 1'b1, ON, 3'b111, 1'b1);
        step_b("b_dn_f0", 1'b0, 1'b0, RD, 3'b111, 1'b0);
        step_b("b_dn_f1", 1'b0, 1'b0, RD, 3'b011, 1'b0);
        step_b("b_dn_f2", 1'b0, 1'b0, RD, 3'b001, 1'b0);
        step_b("b_dn_f3", 1'b0, 1'b0, OFF, 3'b000, 1'b0);
        step_b("b_dn_f4", 1'b0, 1'b0, OFF, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
